// File: rtl/riscv_ifq.sv
// Instruction fetch queue between IFU and IDU: in-order {addr, instr} buffer with
// valid/ready on both sides, optional empty-queue bypass and single-cycle flush.

module riscv_ifq_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clock,
  input logic          reset,
  input logic [CW-1:0] count,
  input logic          push,
  input logic          pop,
  input logic          idu_vld
);

  // Structural invariants of the queue, checked on every active edge.
  always @(posedge clock) begin
    if (!reset) begin
      assert (count <= CW'(DEPTH)) else $error("ifq count above depth");
      assert (!(push && (count == CW'(DEPTH)))) else $error("ifq enqueue while full");
      assert (!(pop && !idu_vld)) else $error("ifq dequeue without valid");
    end
  end

endmodule

module riscv_ifq #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int BYPASS = 0,
  parameter int AFULL  = DEPTH - 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ifu_vld,
  output logic                       ifu_rdy,
  input  logic [XLEN-1:0]            ifu_addr,
  input  logic [ILEN-1:0]            ifu_data,
  output logic                       idu_vld,
  input  logic                       idu_rdy,
  output logic [XLEN-1:0]            idu_addr,
  output logic [ILEN-1:0]            idu_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] addr_mem_q [DEPTH];
  logic [ILEN-1:0] data_mem_q [DEPTH];

  logic live_s, stored_s, byp_s, enq_s, pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Handshake and head-of-queue outputs; a bypassed beat is never stored when taken.
  always_comb begin
    live_s      = ~reset & ~flush;
    stored_s    = (count_q != CW'(0));
    ifu_rdy     = live_s & (count_q < CW'(DEPTH));
    byp_s       = (BYPASS != 0) & live_s & ~stored_s & ifu_vld;
    idu_vld     = (live_s & stored_s) | byp_s;
    idu_addr    = '0;
    idu_data    = '0;
    if (byp_s) begin
      idu_addr = ifu_addr;
      idu_data = ifu_data;
    end else if (live_s & stored_s) begin
      idu_addr = addr_mem_q[rd_ptr_q];
      idu_data = data_mem_q[rd_ptr_q];
    end else begin
      idu_addr = '0;
      idu_data = '0;
    end
    pop_s       = idu_vld & idu_rdy & ~byp_s;
    enq_s       = ifu_vld & ifu_rdy & ~(byp_s & idu_rdy);
    count       = count_q;
    empty       = reset | ~stored_s;
    almost_full = ~reset & (count_q >= CW'(AFULL));
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset | flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; only occupied slots are ever presented.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      addr_mem_q[wr_ptr_q] <= ifu_addr;
      data_mem_q[wr_ptr_q] <= ifu_data;
    end
  end

  riscv_ifq_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clock   (clock),
    .reset   (reset),
    .count   (count_q),
    .push    (enq_s),
    .pop     (pop_s),
    .idu_vld (idu_vld)
  );

endmodule

// File: tb/tb_riscv_ifq.sv
// Bench for riscv_ifq: three instances (D4/no bypass, D3/no bypass, D4/bypass) checked
// against a queue-based reference model, plus directed tables and corner sequences.
module tb_riscv_ifq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset [3], flush [3], ifu_vld [3], ifu_rdy [3];
  logic        idu_vld [3], idu_rdy [3], empty [3], almost_full [3];
  logic [31:0] ifu_addr [3], ifu_data [3], idu_addr [3], idu_data [3];
  logic [4:0]  count [3];

  int nerr = 0;
  int nchk = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 1) ? 3 : 4;
    logic [$clog2(D+1)-1:0] cnt_w;
    riscv_ifq #(.DEPTH(D), .XLEN(32), .ILEN(32), .BYPASS((g == 2) ? 1 : 0), .AFULL(D-1)) u_dut (
      .clock(clock), .reset(reset[g]), .flush(flush[g]),
      .ifu_vld(ifu_vld[g]), .ifu_rdy(ifu_rdy[g]), .ifu_addr(ifu_addr[g]), .ifu_data(ifu_data[g]),
      .idu_vld(idu_vld[g]), .idu_rdy(idu_rdy[g]), .idu_addr(idu_addr[g]), .idu_data(idu_data[g]),
      .count(cnt_w), .empty(empty[g]), .almost_full(almost_full[g]));
    assign count[g] = 5'(cnt_w);
  end

  // Reference model: each instance is an ordered list of stored {addr, data} beats.
  logic [63:0] mq [3][$];

  function automatic int dep(input int i);
    return (i == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b0; flush[i] = 1'b0; ifu_vld[i] = 1'b0; idu_rdy[i] = 1'b0;
      ifu_addr[i] = 32'h0; ifu_data[i] = 32'h0;
    end
  endtask

  task automatic settle();
    #2;
    for (int i = 0; i < 3; i++) begin
      int n;
      logic live, e_vld, e_rdy;
      logic [63:0] head;
      n     = mq[i].size();
      live  = !reset[i] && !flush[i];
      e_rdy = live && (n < dep(i));
      e_vld = live && ((n > 0) || ((i == 2) && ifu_vld[i]));
      head  = !e_vld ? 64'h0 : (n > 0) ? mq[i][0] : {ifu_addr[i], ifu_data[i]};
      chk($sformatf("u%0d ifu_rdy", i), {63'h0, ifu_rdy[i]}, {63'h0, e_rdy});
      chk($sformatf("u%0d idu_vld", i), {63'h0, idu_vld[i]}, {63'h0, e_vld});
      chk($sformatf("u%0d head", i), {idu_addr[i], idu_data[i]}, head);
      chk($sformatf("u%0d count", i), {59'h0, count[i]}, 64'(n));
      chk($sformatf("u%0d empty", i), {63'h0, empty[i]}, {63'h0, reset[i] || (n == 0)});
      chk($sformatf("u%0d almost_full", i), {63'h0, almost_full[i]},
          {63'h0, !reset[i] && (n >= dep(i) - 1)});
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      int n;
      logic live, taken, accepted;
      n        = mq[i].size();
      live     = !reset[i] && !flush[i];
      taken    = live && idu_rdy[i] && ((n > 0) || ((i == 2) && ifu_vld[i]));
      accepted = live && ifu_vld[i] && (n < dep(i));
      if (!live) begin
        mq[i].delete();
      end else if (taken && (n == 0)) begin
        // bypassed beat consumed directly: nothing stored
      end else begin
        if (taken) void'(mq[i].pop_front());
        if (accepted) mq[i].push_back({ifu_addr[i], ifu_data[i]});
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push0(input int i, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    idle_all();
    ifu_vld[i] = 1'b1; ifu_addr[i] = a; ifu_data[i] = d; idu_rdy[i] = rdy;
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] a, d;
    logic        rdy;
    logic        e_irdy, e_ovld;
    logic [31:0] e_a, e_d;
    logic [4:0]  e_cnt;
    logic        e_emp, e_af;
  } vec_t;

  vec_t tv [9];

  initial begin
    int popped;
    tv[0] = '{1'b1, 32'h0, 32'h13,  1'b0, 1'b1, 1'b0, 32'h0, 32'h0,   5'd0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 32'h4, 32'h93,  1'b0, 1'b1, 1'b1, 32'h0, 32'h13,  5'd1, 1'b0, 1'b0};
    tv[2] = '{1'b1, 32'h8, 32'h113, 1'b0, 1'b1, 1'b1, 32'h0, 32'h13,  5'd2, 1'b0, 1'b0};
    tv[3] = '{1'b1, 32'hC, 32'h193, 1'b0, 1'b1, 1'b1, 32'h0, 32'h13,  5'd3, 1'b0, 1'b1};
    tv[4] = '{1'b0, 32'h0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0, 32'h13,  5'd4, 1'b0, 1'b1};
    tv[5] = '{1'b0, 32'h0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4, 32'h93,  5'd3, 1'b0, 1'b1};
    tv[6] = '{1'b0, 32'h0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8, 32'h113, 5'd2, 1'b0, 1'b0};
    tv[7] = '{1'b0, 32'h0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC, 32'h193, 5'd1, 1'b0, 1'b0};
    tv[8] = '{1'b0, 32'h0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0,   5'd0, 1'b1, 1'b0};

    idle_all();
    for (int i = 0; i < 3; i++) reset[i] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    settle();
    advance();
    idle_all();

    // Fill D4 queue to full with IDU stalled, then drain in order.
    for (int k = 0; k < 9; k++) begin
      idle_all();
      ifu_vld[0] = tv[k].vld; ifu_addr[0] = tv[k].a; ifu_data[0] = tv[k].d; idu_rdy[0] = tv[k].rdy;
      settle();
      chk($sformatf("tv%0d ifu_rdy", k), {63'h0, ifu_rdy[0]}, {63'h0, tv[k].e_irdy});
      chk($sformatf("tv%0d idu_vld", k), {63'h0, idu_vld[0]}, {63'h0, tv[k].e_ovld});
      chk($sformatf("tv%0d head", k), {idu_addr[0], idu_data[0]}, {tv[k].e_a, tv[k].e_d});
      chk($sformatf("tv%0d count", k), {59'h0, count[0]}, {59'h0, tv[k].e_cnt});
      chk($sformatf("tv%0d empty", k), {63'h0, empty[0]}, {63'h0, tv[k].e_emp});
      chk($sformatf("tv%0d afull", k), {63'h0, almost_full[0]}, {63'h0, tv[k].e_af});
      advance();
    end

    // D3 wrap: push every cycle with IDU always ready, five beats through.
    popped = 0;
    for (int k = 0; k < 6; k++) begin
      idle_all();
      ifu_vld[1] = (k < 5); ifu_addr[1] = 32'h1000 + 32'(4 * k); ifu_data[1] = 32'(k); idu_rdy[1] = 1'b1;
      settle();
      chk("wrap count<=2", {63'h0, count[1] <= 5'd2}, 64'h1);
      if (idu_vld[1]) begin
        chk("wrap order", {32'h0, idu_addr[1]}, {32'h0, 32'h1000 + 32'(4 * popped)});
        popped++;
      end
      advance();
    end
    chk("wrap popped", 64'(popped), 64'd5);

    // Steady enqueue+dequeue at count 2: output lags input by two beats.
    push0(0, 32'h2000, 32'hA0, 1'b0); settle(); advance();
    push0(0, 32'h2004, 32'hA1, 1'b0); settle(); advance();
    for (int k = 0; k < 10; k++) begin
      push0(0, 32'h2008 + 32'(4 * k), 32'hA2 + 32'(k), 1'b1);
      settle();
      chk("steady count", {59'h0, count[0]}, 64'd2);
      chk("steady head", {32'h0, idu_addr[0]}, {32'h0, 32'h2000 + 32'(4 * k)});
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      idle_all(); idu_rdy[0] = 1'b1; settle(); advance();
    end

    // Bypass: taken same cycle, then stalled and replayed from storage.
    push0(2, 32'h100, 32'h513, 1'b1);
    settle();
    chk("byp vld", {63'h0, idu_vld[2]}, 64'h1);
    chk("byp addr", {32'h0, idu_addr[2]}, 64'h100);
    advance();
    push0(2, 32'h100, 32'h513, 1'b0);
    settle();
    chk("byp count0", {59'h0, count[2]}, 64'd0);
    chk("byp stall addr", {32'h0, idu_addr[2]}, 64'h100);
    advance();
    idle_all();
    settle();
    chk("byp stored count", {59'h0, count[2]}, 64'd1);
    chk("byp stored addr", {32'h0, idu_addr[2]}, 64'h100);
    advance();
    idle_all(); idu_rdy[2] = 1'b1; settle(); advance();
    idle_all(); settle();
    chk("byp drained", {59'h0, count[2]}, 64'd0);
    advance();

    // Flush with three queued beats while IFU is presenting.
    for (int k = 0; k < 3; k++) begin
      push0(0, 32'h300 + 32'(4 * k), 32'hB0, 1'b0); settle(); advance();
    end
    push0(0, 32'h30C, 32'hB3, 1'b0); flush[0] = 1'b1;
    settle();
    chk("flush ifu_rdy", {63'h0, ifu_rdy[0]}, 64'h0);
    chk("flush idu_vld", {63'h0, idu_vld[0]}, 64'h0);
    advance();
    push0(0, 32'h200, 32'hC0, 1'b0);
    settle();
    chk("post-flush count", {59'h0, count[0]}, 64'd0);
    chk("post-flush empty", {63'h0, empty[0]}, 64'h1);
    advance();
    idle_all(); idu_rdy[0] = 1'b1;
    settle();
    chk("post-flush first", {32'h0, idu_addr[0]}, 64'h200);
    advance();

    // Mid-stream reset with two beats queued.
    push0(0, 32'h400, 32'hD0, 1'b0); settle(); advance();
    push0(0, 32'h404, 32'hD1, 1'b0); settle(); advance();
    idle_all(); reset[0] = 1'b1;
    settle();
    chk("rst ifu_rdy", {63'h0, ifu_rdy[0]}, 64'h0);
    chk("rst idu_vld", {63'h0, idu_vld[0]}, 64'h0);
    advance();
    idle_all();
    settle();
    chk("after rst count", {59'h0, count[0]}, 64'd0);
    chk("after rst idu_vld", {63'h0, idu_vld[0]}, 64'h0);
    chk("after rst ifu_rdy", {63'h0, ifu_rdy[0]}, 64'h1);
    advance();

    // Random traffic on all instances against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        reset[i]    = ($urandom_range(0, 59) == 0);
        flush[i]    = ($urandom_range(0, 24) == 0);
        ifu_vld[i]  = ($urandom_range(0, 3) != 0);
        idu_rdy[i]  = ($urandom_range(0, 2) != 0);
        ifu_addr[i] = $urandom;
        ifu_data[i] = $urandom;
      end
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
